// File: rtl/mont_mul_front.sv
// rtl/mont_mul_front.sv - three-stage pipelined front half of the Dilithium Montgomery multiplier
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   clear               synchronous flush of all in-flight entries
//   in_valid/in_ready   input handshake for in_b, in_z, in_tag
//   out_valid/out_ready output handshake for out_a, out_t, out_tag
//   out_a               signed 64-bit product b*z
//   out_t               signed low32(out_a[31:0]*QINV)
//   busy                any stage holds a valid entry

module mont_mul_front #(
    parameter int DQ    = 8380417,
    parameter int QINV  = 58728449,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_a,
    output logic [31:0]      out_t,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // QINV must be the inverse of the downstream modulus mod 2^32.
    localparam logic [63:0] DQ_QINV = 64'(DQ) * 64'(QINV);
    localparam logic [31:0] QINV_C  = 32'(QINV);

    if (DQ_QINV[31:0] != 32'd1) begin : g_bad_qinv
        $error("QINV is not the inverse of DQ mod 2^32");
    end

    logic             s1_v_q, s1_v_d;
    logic [31:0]      s1_b_q, s1_b_d;
    logic [31:0]      s1_z_q, s1_z_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_v_q, s2_v_d;
    logic [63:0]      s2_a_q, s2_a_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s3_v_q, s3_v_d;
    logic [63:0]      s3_a_q, s3_a_d;
    logic [31:0]      s3_t_q, s3_t_d;
    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;

    logic s1_load, s2_load, s3_load;
    logic [63:0] prod_c;
    logic [31:0] t_c;

    // Bubble-collapsing load chain: a stage accepts whenever it is empty
    // or its successor is taking its current content.
    assign s3_load = !s3_v_q || out_ready;
    assign s2_load = !s2_v_q || s3_load;
    assign s1_load = !s1_v_q || s2_load;

    assign in_ready = s1_load && !clear;

    // Low 64 bits of the product of sign-extended operands equal the
    // signed 32x32 product.
    assign prod_c = {{32{s1_b_q[31]}}, s1_b_q} * {{32{s1_z_q[31]}}, s1_z_q};
    assign t_c    = s2_a_q[31:0] * QINV_C;

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_b_d   = s1_b_q;
        s1_z_d   = s1_z_q;
        s1_tag_d = s1_tag_q;
        s2_v_d   = s2_v_q;
        s2_a_d   = s2_a_q;
        s2_tag_d = s2_tag_q;
        s3_v_d   = s3_v_q;
        s3_a_d   = s3_a_q;
        s3_t_d   = s3_t_q;
        s3_tag_d = s3_tag_q;
        if (clear) begin
            // Flush drops entries but leaves data registers untouched.
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
            s3_v_d = 1'b0;
        end else begin
            if (s3_load) begin
                s3_v_d   = s2_v_q;
                s3_a_d   = s2_a_q;
                s3_t_d   = t_c;
                s3_tag_d = s2_tag_q;
            end
            if (s2_load) begin
                s2_v_d   = s1_v_q;
                s2_a_d   = prod_c;
                s2_tag_d = s1_tag_q;
            end
            if (s1_load) begin
                s1_v_d   = in_valid;
                s1_b_d   = in_b;
                s1_z_d   = in_z;
                s1_tag_d = in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_b_q   <= '0;
            s1_z_q   <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_a_q   <= '0;
            s2_tag_q <= '0;
            s3_v_q   <= 1'b0;
            s3_a_q   <= '0;
            s3_t_q   <= '0;
            s3_tag_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_b_q   <= s1_b_d;
            s1_z_q   <= s1_z_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_a_q   <= s2_a_d;
            s2_tag_q <= s2_tag_d;
            s3_v_q   <= s3_v_d;
            s3_a_q   <= s3_a_d;
            s3_t_q   <= s3_t_d;
            s3_tag_q <= s3_tag_d;
        end
    end

    assign out_valid = s3_v_q;
    assign out_a     = s3_a_q;
    assign out_t     = s3_t_q;
    assign out_tag   = s3_tag_q;
    assign busy      = s1_v_q || s2_v_q || s3_v_q;

endmodule

// File: tb/tb_mont_mul_front.sv
// tb/tb_mont_mul_front.sv - scoreboard testbench for mont_mul_front
module tb_mont_mul_front;

    localparam int  TAG_W = 8;
    localparam longint DQ   = 8380417;
    localparam int  QINV  = 58728449;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_b;
    logic [31:0]      in_z;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_a;
    logic [31:0]      out_t;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    mont_mul_front #(.DQ(8380417), .QINV(QINV), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_b(in_b), .in_z(in_z), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_t(out_t), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      a;
        logic [31:0]      t;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          lat_chk  = 1'b0;
    logic [63:0] drv_a;
    logic [31:0] drv_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_a(input logic [31:0] b, input logic [31:0] z);
        longint sb, sz;
        sb = longint'($signed(b));
        sz = longint'($signed(z));
        return 64'(sb * sz);
    endfunction

    function automatic logic [31:0] model_t(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo * 32'(QINV);
    endfunction

    // Monitor / scoreboard: pushes on observed acceptance, pops on output transfer.
    always @(negedge clk) begin : mon
        sb_entry_t e;
        longint    sa, st, diff, r;
        if (rst || clear) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_output", 64'(out_tag), 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_t", 64'(out_t), 64'(e.t));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                    if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd3);
                    sa   = longint'(out_a);
                    st   = longint'($signed(out_t));
                    diff = sa - st * DQ;
                    r    = diff >>> 32;
                    chk("reduce_congruent",
                        64'((diff[31:0] == 32'd0) && ((((r <<< 32) - sa) % DQ) == 0)), 64'd1);
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back('{drv_a, drv_t, in_tag, cyc});
        end
    end

    task automatic send(input logic [31:0] b, input logic [31:0] z, input logic [TAG_W-1:0] tag,
                        input logic [63:0] ea, input logic [31:0] et);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_b     = b;
        in_z     = z;
        in_tag   = tag;
        drv_a    = ea;
        drv_t    = et;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] b, input logic [31:0] z, input logic [TAG_W-1:0] tag);
        logic [63:0] a;
        a = model_a(b, z);
        send(b, z, tag, a, model_t(a));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((busy || sb_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int acc_cnt;
    bit tog_done;
    logic [31:0] vb[3];
    logic [31:0] vz[3];

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_b = 32'd5; in_z = 32'd7; in_tag = 8'h11; drv_a = '0; drv_t = '0;

        // Reset with in_valid held high.
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_out_t", 64'(out_t), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed values, hand-computed.
        lat_chk = 1'b1;
        send(32'd1, 32'd1, 8'h01, 64'd1, 32'd58728449);
        repeat (4) @(posedge clk);
        #1;
        send(32'hFFFFFFFF, 32'd1, 8'h02, 64'hFFFFFFFFFFFFFFFF, 32'hFC7FDFFF);
        repeat (4) @(posedge clk);
        #1;
        send(32'd65536, 32'd65536, 8'h03, 64'h0000000100000000, 32'd0);
        send(32'd2, 32'd3, 8'h04, 64'd6, 32'd352370694);
        send(32'hFFFFFFF9, 32'hFFFFFFFB, 8'h05, 64'd35, 32'd2055495715);
        drain();

        // Back-to-back random stream.
        for (int i = 0; i < 100; i++)
            send_m($urandom, $urandom, 8'(i));
        drain();
        lat_chk = 1'b0;

        // Backpressure: only 3 entries fit with out_ready low.
        vb[0] = 32'd7;          vz[0] = 32'hFFFFFFFB;
        vb[1] = 32'd123456;     vz[1] = 32'hFFF60211;
        vb[2] = 32'hFF800200;   vz[2] = 32'd2;
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_b   = vb[i % 3];
            in_z   = vz[i % 3];
            in_tag = 8'(8'h40 + i);
            drv_a  = model_a(in_b, in_z);
            drv_t  = model_t(drv_a);
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accept_count", 64'(acc_cnt), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_stable_a", out_a, 64'hFFFFFFFFFFFFFFDD);
            chk("bp_stable_t", 64'(out_t), 64'(model_t(64'hFFFFFFFFFFFFFFDD)));
            chk("bp_stable_tag", 64'(out_tag), 64'h40);
        end
        @(posedge clk); #1;
        drain();

        // Random out_ready toggling.
        tog_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send_m($urandom, $urandom, 8'(8'h80 + i));
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        // Flush with 3 entries in flight.
        out_ready = 1'b0;
        send_m(32'd11, 32'd13, 8'hA1);
        send_m(32'd17, 32'd19, 8'hA2);
        send_m(32'd23, 32'd29, 8'hA3);
        clear = 1'b1;
        in_valid = 1'b1; in_b = 32'd9; in_z = 32'd9; in_tag = 8'hEE;
        @(negedge clk);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(32'd2, 32'd3, 8'hA4, 64'd6, 32'd352370694);
        drain();
        lat_chk = 1'b0;

        // Asynchronous reset while stalled and full.
        out_ready = 1'b0;
        send_m(32'd31, 32'd37, 8'hB1);
        send_m(32'd41, 32'd43, 8'hB2);
        send_m(32'd47, 32'd53, 8'hB3);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("full_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_out_a", out_a, 64'd0);
        chk("async_rst_out_t", 64'(out_t), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_async_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(32'd1, 32'd1, 8'hC1, 64'd1, 32'd58728449);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
